fib_index_finder: RTL

//  Inverse of the Fibonacci generator: given a word, iteratively decides whether it is a

---
 rtl/fib_index_finder.sv | 114 +++++++++++
 1 files changed

// File: rtl/fib_index_finder.sv
// Fibonacci index finder: decides iteratively whether a word is a Fibonacci number
// and returns its index (or the largest index whose Fibonacci value is below it).
module fib_index_finder #(
  parameter int wordsize = 10,
  parameter int IDXW     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [wordsize-1:0] value,
  output logic                busy,
  output logic                ready,
  output logic                found,
  output logic [IDXW-1:0]     index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [wordsize-1:0] v, v_nx;
  logic [wordsize-1:0] a, a_nx;
  logic [wordsize-1:0] b, b_nx;
  logic [IDXW-1:0]     idx, idx_nx;
  logic [IDXW-1:0]     index_nx;
  logic                found_nx;
  logic [wordsize:0]   sum;

  // One extra bit so the carry flags overflow; a wrapped sum never reaches b.
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves one unassigned (no latch).
    state_nx = state;
    v_nx     = v;
    a_nx     = a;
    b_nx     = b;
    idx_nx   = idx;
    found_nx = found;
    index_nx = index;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (value == '0) begin
            state_nx = DONE;
            found_nx = 1'b1;
            index_nx = '0;
          end else begin
            state_nx = ITER;
            v_nx     = value;
            a_nx     = '0;
            b_nx     = wordsize'(1);
            idx_nx   = IDXW'(1);
          end
        end
      end

      ITER: begin
        if (b == v) begin
          state_nx = DONE;
          found_nx = 1'b1;
          index_nx = idx;
        end else if (b > v) begin
          state_nx = DONE;
          found_nx = 1'b0;
          index_nx = idx - IDXW'(1);
        end else if (sum[wordsize]) begin
          // Next term does not fit: v lies above the largest representable Fibonacci value.
          state_nx = DONE;
          found_nx = 1'b0;
          index_nx = idx;
        end else begin
          a_nx   = b;
          b_nx   = sum[wordsize-1:0];
          idx_nx = idx + IDXW'(1);
        end
      end

      DONE: state_nx = IDLE;

      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      v     <= '0;
      a     <= '0;
      b     <= '0;
      idx   <= '0;
      found <= 1'b0;
      index <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      state <= state_nx;
      v     <= v_nx;
      a     <= a_nx;
      b     <= b_nx;
      idx   <= idx_nx;
      found <= found_nx;
      index <= index_nx;
      busy  <= (state_nx != IDLE);
      ready <= (state_nx == DONE);
    end
  end

endmodule
